// File: rtl/fb_write_arbiter.sv
// Three-requester frame-buffer write arbiter with burst timeout and address bounds check.
// Define FB_ARB_ROUND_ROBIN_EN for round-robin selection; the default is fixed priority 0 > 1 > 2.
module fb_write_arbiter #(
   parameter int FB_DEPTH  = 76800,
   parameter int MAX_BURST = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req,
   input  logic [2:0]  wr_en,
   input  logic [2:0]  last,
   input  logic [50:0] addr_in,
   input  logic [71:0] data_in,
   output logic [2:0]  gnt,
   output logic        fb_we,
   output logic [16:0] fb_addr,
   output logic [23:0] fb_data,
   output logic        busy,
   output logic        timeout,
   output logic [15:0] drop_cnt
);

   localparam int          CW        = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
   localparam logic [31:0] DEPTH_W   = 32'(FB_DEPTH);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t        state_reg;
   logic [1:0]    owner_reg;
   logic [2:0]    gnt_reg;
   logic [CW-1:0] burst_cnt_reg;
   logic          fb_we_reg;
   logic [16:0]   fb_addr_reg;
   logic [23:0]   fb_data_reg;
   logic          timeout_reg;
   logic [15:0]   drop_cnt_reg;

   logic [16:0] addr_arr [3];
   logic [23:0] data_arr [3];

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
         assign addr_arr[gi] = addr_in[17*gi +: 17];
         assign data_arr[gi] = data_in[24*gi +: 24];
      end
   endgenerate

   logic        own_wr, own_last, own_req, own_in_range;
   logic [16:0] own_addr;
   logic [23:0] own_data;

   assign own_wr       = wr_en[owner_reg];
   assign own_last     = last[owner_reg];
   assign own_req      = req[owner_reg];
   assign own_addr     = addr_arr[owner_reg];
   assign own_data     = data_arr[owner_reg];
   assign own_in_range = 32'(own_addr) < DEPTH_W;

   logic [1:0] sel_idx;

`ifdef FB_ARB_ROUND_ROBIN_EN
   // ptr_reg holds the index the next search starts from: (last granted + 1) mod 3.
   logic [1:0] ptr_reg;

   always_comb begin
      sel_idx = 2'd0;
      for (int k = 2; k >= 0; k--) begin
         if (req[2'((int'(ptr_reg) + k) % 3)])
            sel_idx = 2'((int'(ptr_reg) + k) % 3);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         ptr_reg <= 2'd0;
      else if (state_reg == IDLE && req != 3'b000)
         ptr_reg <= (sel_idx == 2'd2) ? 2'd0 : sel_idx + 2'd1;
   end
`else
   always_comb begin
      sel_idx = 2'd2;
      if (req[0])
         sel_idx = 2'd0;
      else if (req[1])
         sel_idx = 2'd1;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         owner_reg     <= 2'd0;
         gnt_reg       <= 3'b000;
         burst_cnt_reg <= '0;
         fb_we_reg     <= 1'b0;
         fb_addr_reg   <= 17'd0;
         fb_data_reg   <= 24'd0;
         timeout_reg   <= 1'b0;
         drop_cnt_reg  <= 16'd0;
      end else begin
         fb_we_reg   <= 1'b0;
         timeout_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (req != 3'b000) begin
                  owner_reg     <= sel_idx;
                  gnt_reg       <= 3'b001 << sel_idx;
                  burst_cnt_reg <= '0;
                  state_reg     <= GRANT;
               end
            end
            GRANT: begin
               if (own_wr) begin
                  if (own_in_range) begin
                     fb_we_reg   <= 1'b1;
                     fb_addr_reg <= own_addr;
                     fb_data_reg <= own_data;
                  end else if (drop_cnt_reg != 16'hFFFF) begin
                     drop_cnt_reg <= drop_cnt_reg + 16'd1;
                  end
               end
               // Timeout only flags a release that nothing else would have caused.
               if ((own_wr && own_last) || !own_req || burst_cnt_reg == CNT_LAST) begin
                  gnt_reg     <= 3'b000;
                  state_reg   <= GAP;
                  timeout_reg <= (burst_cnt_reg == CNT_LAST) && own_req && !(own_wr && own_last);
               end else begin
                  burst_cnt_reg <= burst_cnt_reg + 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign gnt      = gnt_reg;
   assign busy     = (state_reg == GRANT);
   assign fb_we    = fb_we_reg;
   assign fb_addr  = fb_addr_reg;
   assign fb_data  = fb_data_reg;
   assign timeout  = timeout_reg;
   assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: single burst, contention, timeout, bounds,
// non-owner isolation and mid-burst reset, with hand-computed expectations.
module tb_fb_write_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req, wr_en, last;
   logic [50:0] addr_in;
   logic [71:0] data_in;
   logic [2:0]  gnt;
   logic        fb_we, busy, timeout;
   logic [16:0] fb_addr;
   logic [23:0] fb_data;
   logic [15:0] drop_cnt;

   int n_cmp = 0;
   int n_err = 0;

   fb_write_arbiter #(.FB_DEPTH(76800), .MAX_BURST(8)) dut (
      .clk(clk), .rst(rst), .req(req), .wr_en(wr_en), .last(last),
      .addr_in(addr_in), .data_in(data_in), .gnt(gnt), .fb_we(fb_we),
      .fb_addr(fb_addr), .fb_data(fb_data), .busy(busy), .timeout(timeout),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // Inputs driven here are sampled at the next edge; outputs read afterwards reflect the edge just passed.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input int i, input logic [16:0] a);
      addr_in[17*i +: 17] = a;
   endtask

   task automatic set_data(input int i, input logic [23:0] d);
      data_in[24*i +: 24] = d;
   endtask

   task automatic idle_inputs();
      req = 3'b000; wr_en = 3'b000; last = 3'b000;
   endtask

   int exp_idx [4];

   initial begin
      rst = 1'b1; idle_inputs(); addr_in = '0; data_in = '0;
      step(); step();
      rst = 1'b0;
      check_eq("rst_gnt", 32'(gnt), 32'h0);
      check_eq("rst_fb_we", 32'(fb_we), 32'h0);
      check_eq("rst_fb_addr", 32'(fb_addr), 32'h0);
      check_eq("rst_fb_data", 32'(fb_data), 32'h0);
      check_eq("rst_busy", 32'(busy), 32'h0);
      check_eq("rst_timeout", 32'(timeout), 32'h0);
      check_eq("rst_drop_cnt", 32'(drop_cnt), 32'h0);

      // Single requester, four writes with last on the fourth
      req = 3'b001;
      step();
      check_eq("single_gnt", 32'(gnt), 32'h1);
      check_eq("single_busy", 32'(busy), 32'h1);
      for (int i = 0; i < 4; i++) begin
         wr_en = 3'b001; last = (i == 3) ? 3'b001 : 3'b000;
         set_addr(0, 17'(i)); set_data(0, 24'h00FF00);
         step();
         check_eq($sformatf("single_we%0d", i), 32'(fb_we), 32'h1);
         check_eq($sformatf("single_addr%0d", i), 32'(fb_addr), 32'(i));
         check_eq($sformatf("single_data%0d", i), 32'(fb_data), 32'h00FF00);
         check_eq($sformatf("single_gnt%0d", i), 32'(gnt), (i == 3) ? 32'h0 : 32'h1);
      end
      wr_en = 3'b000; last = 3'b000;
      step();
      check_eq("gap_gnt", 32'(gnt), 32'h0);
      check_eq("gap_fb_we", 32'(fb_we), 32'h0);
      check_eq("gap_busy", 32'(busy), 32'h0);
      step();
      check_eq("regrant_gnt", 32'(gnt), 32'h1);
      req = 3'b000;
      step();
      check_eq("reqlow_release", 32'(gnt), 32'h0);
      step(); step();

      // Contention with every requester writing one word with last
      rst = 1'b1; step(); rst = 1'b0;
`ifdef FB_ARB_ROUND_ROBIN_EN
      exp_idx = '{0, 1, 2, 0};
`else
      exp_idx = '{0, 0, 0, 0};
`endif
      for (int i = 0; i < 3; i++) begin
         set_addr(i, 17'(10 + i)); set_data(i, 24'(32'h111111 * (i + 1)));
      end
      req = 3'b111; wr_en = 3'b111; last = 3'b111;
      for (int k = 0; k < 4; k++) begin
         step();
         check_eq($sformatf("cont_gnt%0d", k), 32'(gnt), 32'h1 << exp_idx[k]);
         step();
         check_eq($sformatf("cont_we%0d", k), 32'(fb_we), 32'h1);
         check_eq($sformatf("cont_addr%0d", k), 32'(fb_addr), 32'(10 + exp_idx[k]));
         check_eq($sformatf("cont_rel%0d", k), 32'(gnt), 32'h0);
         step();
      end
      idle_inputs();
      step(); step();

      // Timeout with MAX_BURST=8: requester 1 streams without last
      req = 3'b010;
      step();
      check_eq("to_gnt", 32'(gnt), 32'h2);
      wr_en = 3'b010;
      for (int k = 0; k < 8; k++) begin
         set_addr(1, 17'(100 + k));
         step();
         check_eq($sformatf("to_we%0d", k), 32'(fb_we), 32'h1);
         check_eq($sformatf("to_addr%0d", k), 32'(fb_addr), 32'(100 + k));
         check_eq($sformatf("to_gnt%0d", k), 32'(gnt), (k == 7) ? 32'h0 : 32'h2);
         check_eq($sformatf("to_pulse%0d", k), 32'(timeout), (k == 7) ? 32'h1 : 32'h0);
      end
      step();
      check_eq("to_pulse_end", 32'(timeout), 32'h0);
      check_eq("to_gap_we", 32'(fb_we), 32'h0);
      idle_inputs();
      step(); step();

      // Address bounds
      req = 3'b001;
      step();
      wr_en = 3'b001; set_addr(0, 17'd76800);
      step();
      check_eq("oob_we", 32'(fb_we), 32'h0);
      check_eq("oob_drop", 32'(drop_cnt), 32'h1);
      set_addr(0, 17'd76799); last = 3'b001;
      step();
      check_eq("inb_we", 32'(fb_we), 32'h1);
      check_eq("inb_addr", 32'(fb_addr), 32'd76799);
      check_eq("inb_drop", 32'(drop_cnt), 32'h1);
      idle_inputs();
      step(); step();

      // Non-owner isolation: requester 0 toggles wr_en at addr 5 while requester 1 owns
      req = 3'b010; set_addr(0, 17'd5); set_addr(1, 17'd7);
      step();
      check_eq("iso_gnt", 32'(gnt), 32'h2);
      for (int k = 0; k < 4; k++) begin
         wr_en = (k % 2 == 0) ? 3'b001 : 3'b000;
         step();
         check_eq($sformatf("iso_we%0d", k), 32'(fb_we), 32'h0);
      end
      wr_en = 3'b010; last = 3'b010;
      step();
      check_eq("iso_own_we", 32'(fb_we), 32'h1);
      check_eq("iso_own_addr", 32'(fb_addr), 32'd7);
      idle_inputs();
      step(); step();

      // Reset in the middle of a requester 2 burst
      req = 3'b100;
      step();
      check_eq("mid_gnt", 32'(gnt), 32'h4);
      wr_en = 3'b100; set_addr(2, 17'd20);
      step();
      check_eq("mid_we", 32'(fb_we), 32'h1);
      rst = 1'b1;
      step();
      check_eq("mid_rst_gnt", 32'(gnt), 32'h0);
      check_eq("mid_rst_we", 32'(fb_we), 32'h0);
      check_eq("mid_rst_drop", 32'(drop_cnt), 32'h0);
      check_eq("mid_rst_busy", 32'(busy), 32'h0);
      rst = 1'b0; req = 3'b000;
      step();
      check_eq("post_rst_we", 32'(fb_we), 32'h0);
      check_eq("post_rst_gnt", 32'(gnt), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 SHALL have parameter FB_DEPTH, default 76800; number of valid frame-buffer words (320x240).
REQ-002 SHALL have parameter MAX_BURST, default 1024; maximum granted cycles per tenure.
REQ-003 SHALL have port clk, input, 1; single clock, 100 MHz buffered system clock.
REQ-004 SHALL have port rst, input, 1; synchronous, active-high reset.
REQ-005 SHALL have port req, input, 3; per-requester access request; index 0 = map, 1 = sprite, 2 = clear.
REQ-006 SHALL have port wr_en, input, 3; per-requester write strobe, honoured only while granted.
REQ-007 SHALL have port last, input, 3; per-requester end-of-burst marker, qualified by wr_en.
REQ-008 SHALL have port addr_in, input, 51; three packed 17-bit addresses, requester i at [17i+16:17i].
REQ-009 SHALL have port data_in, input, 72; three packed 24-bit RGB words, requester i at [24i+23:24i].
REQ-010 SHALL have port gnt, output, 3; one-hot or zero grant.
REQ-011 SHALL have port fb_we, output, 1; frame-buffer write enable.
REQ-012 SHALL have port fb_addr, output, 17; frame-buffer write address.
REQ-013 SHALL have port fb_data, output, 24; frame-buffer write data.
REQ-014 SHALL have port busy, output, 1; high while any grant is held.
REQ-015 SHALL have port timeout, output, 1; one-cycle pulse on forced release.
REQ-016 SHALL have port drop_cnt, output, 16; saturating count of out-of-range writes discarded.

Function
REQ-017 SHALL implement states IDLE, GRANT, GAP.
REQ-018 IDLE: when any req bit is high, SHALL select one requester, register gnt one-hot and enter GRANT; gnt SHALL be visible the cycle after req is sampled.
REQ-019 GRANT: the owner's wr_en/addr/data SHALL be registered to fb_we/fb_addr/fb_data with exactly 1-cycle latency; non-owner wr_en SHALL be ignored.
REQ-020 GRANT SHALL end, with gnt cleared on the next edge and a move to GAP, on any of:
- owner wr_en&last, where that final write is still forwarded;
- owner req low;
- burst counter reaching MAX_BURST, with timeout pulsed.
REQ-021 GAP SHALL last exactly one cycle with gnt=0, then return to IDLE; this guarantees one bubble between tenures.
REQ-022 Burst counter SHALL clear on entry to GRANT, increment every GRANT cycle, and force release when it equals MAX_BURST-1.
REQ-023 A write with addr >= FB_DEPTH SHALL be suppressed (fb_we=0) and increment drop_cnt, which saturates at 16'hFFFF.
REQ-024 busy SHALL equal (state==GRANT).
REQ-025 Simultaneous release and new request from same requester: request SHALL be re-arbitrated only after GAP.

Reset
REQ-026 On rst high at a clk edge, SHALL force state IDLE, gnt=0, fb_we=0, fb_addr=0, fb_data=0, busy=0, timeout=0, drop_cnt=0, burst counter=0, round-robin pointer=0.
REQ-027 Reset mid-burst SHALL abort the tenure with no further fb_we until a new grant.

Configuration
REQ-028 With macro FB_ARB_ROUND_ROBIN_EN defined, selection SHALL be round-robin: search starts at index (last granted + 1) mod 3; the pointer updates on each grant.
REQ-029 Without FB_ARB_ROUND_ROBIN_EN, selection SHALL be fixed priority map(0) > sprite(1) > clear(2), with no pointer state.

Verification
REQ-030 Single requester: req[0]=1, then 4 writes at addr 0..3 with data 24'h00FF00 and last on the 4th -> gnt=3'b001 one cycle after req; fb_we pulses with addr 0..3 one cycle after each wr_en; gnt=0 after the last write; one GAP cycle follows.
REQ-031 Contention: req=3'b111 held, each requester issues one write with last -> priority build grants 0,0,0 repeatedly; round-robin build grants 0,1,2,0.
REQ-032 Timeout: MAX_BURST=8, requester 1 streams writes without last -> gnt released after 8 GRANT cycles, timeout=1 for one cycle, 8 writes forwarded.
REQ-033 Bounds: write addr 76800 then 76799 -> first suppressed with drop_cnt=1; second forwarded with fb_addr=17'd76799.
REQ-034 Reset mid-burst: rst asserted during a requester 2 burst -> next cycle gnt=0, fb_we=0, drop_cnt=0, state IDLE.
REQ-035 Non-owner isolation: requester 1 granted, requester 0 toggles wr_en with addr 5 -> no fb write to addr 5.
